rvvi_depacketizer: RTL



---
 rtl/rvvi_depacketizer_pkg.sv | 35 +++
 rtl/rvvi_frame_buffer.sv | 39 +++
 rtl/rvvi_depacketizer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rvvi_depacketizer_pkg.sv
// Shared RVVI trace-link constants: record/frame sizing, header offsets and
// the default link addressing used by both the packetizer and depacketizer.
package rvvi_depacketizer_pkg;

    localparam int XLEN = 64;

    // Frame header layout (bit offsets into the reassembled frame)
    localparam int SRC_OFF     = 0;
    localparam int DST_OFF     = 48;
    localparam int ETYPE_OFF   = 96;
    localparam int PAYLOAD_OFF = 112;

    // Default link addressing
    localparam logic [47:0] DEFAULT_DST_MAC  = 48'h8F54_0000_1654;
    localparam logic [15:0] DEFAULT_ETH_TYPE = 16'h005c;

    // Beat counter: 10 bits, saturating
    localparam int          WCNT_W   = 10;
    localparam logic [9:0]  WCNT_MAX = 10'd1023;

    // Receive FSM encoding
    localparam logic STATE_RECV = 1'b0;
    localparam logic STATE_HOLD = 1'b1;

    // Width of the compressed RVVI record for a given number of CSR slots
    function automatic int rvviWidth(input int csrs);
        return 72 + 5 * XLEN + csrs * (XLEN + 16);
    endfunction

    // Number of 32-bit beats needed to carry header plus record
    function automatic int rvviFrameWords(input int recordWidth);
        return (PAYLOAD_OFF + recordWidth + 31) / 32;
    endfunction

endpackage

// File: rtl/rvvi_frame_buffer.sv
// Indexed word store for one frame. Exposes the frame as it will stand after
// the current write so that the last beat can be checked and captured in the
// same cycle it arrives.
module rvvi_frame_buffer #(
    parameter int FRAME_WORDS = 24,
    parameter int IDX_W       = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [IDX_W-1:0]         wrIdx,
    input  logic [31:0]              wrData,
    output logic [FRAME_WORDS*32-1:0] frameNext
);

    logic [FRAME_WORDS*32-1:0] frameR;

    // Merge the incoming word into its slot of the stored frame
    always_comb begin
        frameNext = frameR;
        for (int i = 0; i < FRAME_WORDS; i++) begin
            if (we && (wrIdx == IDX_W'(i))) begin
                frameNext[i*32 +: 32] = wrData;
            end else begin
                frameNext[i*32 +: 32] = frameR[i*32 +: 32];
            end
        end
    end

    // Frame storage; contents are discarded on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            frameR <= '0;
        end else begin
            frameR <= frameNext;
        end
    end

endmodule

// File: rtl/rvvi_depacketizer.sv
// Receive side of the RVVI trace link: reassembles 32-bit beats into a frame,
// validates length, strobes and header, and hands the recovered record to a
// consumer over valid/ready. Dropped frames never disturb the presented record.
module rvvi_depacketizer
    import rvvi_depacketizer_pkg::*;
#(
    parameter int          MAX_CSRS = 3,
    parameter logic [47:0] DST_MAC  = DEFAULT_DST_MAC,
    parameter logic [15:0] ETH_TYPE = DEFAULT_ETH_TYPE
) (
    input  logic                             m_axi_aclk,
    input  logic                             reset,
    input  logic [31:0]                      RvviAxiRdata,
    input  logic [3:0]                       RvviAxiRstrb,
    input  logic                             RvviAxiRlast,
    input  logic                             RvviAxiRvalid,
    output logic                             RvviAxiRready,
    output logic [rvviWidth(MAX_CSRS)-1:0]   rvvi,
    output logic                             RvviValid,
    input  logic                             RvviReady,
    output logic                             FrameErr,
    output logic [31:0]                      FrameCount,
    output logic [31:0]                      DropCount
);

    localparam int RVVI_W      = rvviWidth(MAX_CSRS);
    localparam int FRAME_WORDS = rvviFrameWords(RVVI_W);
    localparam int FRAME_BITS  = FRAME_WORDS * 32;
    localparam int IDX_W       = $clog2(FRAME_WORDS);

    logic                  state;
    logic [WCNT_W-1:0]     wordCount;
    logic                  stickyErr;
    logic                  beat;
    logic                  we;
    logic                  stickyNext;
    logic                  lastBeat;
    logic                  goodFrame;
    logic                  badFrame;
    logic [FRAME_BITS-1:0] frameNext;
    logic                  unusedBits;

    // Beats are only taken while receiving and out of reset
    assign RvviAxiRready = (state == STATE_RECV) && !reset;
    assign RvviValid     = (state == STATE_HOLD);
    assign beat          = RvviAxiRvalid && RvviAxiRready;
    assign we            = beat && (wordCount < WCNT_W'(FRAME_WORDS));
    // Source MAC and pad bits are carried but not inspected
    assign unusedBits    = ^frameNext;

    rvvi_frame_buffer #(
        .FRAME_WORDS (FRAME_WORDS),
        .IDX_W       (IDX_W)
    ) u_buffer (
        .clk       (m_axi_aclk),
        .reset     (reset),
        .we        (we),
        .wrIdx     (wordCount[IDX_W-1:0]),
        .wrData    (RvviAxiRdata),
        .frameNext (frameNext)
    );

    // Frame verdict on the last beat, using the header after this beat's write
    always_comb begin
        stickyNext = stickyErr;
        lastBeat   = 1'b0;
        goodFrame  = 1'b0;
        badFrame   = 1'b0;
        if (beat) begin
            stickyNext = stickyErr || (RvviAxiRstrb != 4'hF);
            lastBeat   = RvviAxiRlast;
        end else begin
            stickyNext = stickyErr;
        end
        if (lastBeat) begin
            goodFrame = (wordCount == WCNT_W'(FRAME_WORDS - 1)) &&
                        !stickyNext &&
                        (frameNext[DST_OFF +: 48] == DST_MAC) &&
                        (frameNext[ETYPE_OFF +: 16] == ETH_TYPE);
            badFrame  = !goodFrame;
        end else begin
            goodFrame = 1'b0;
            badFrame  = 1'b0;
        end
    end

    // Receive/hold state machine
    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            state <= STATE_RECV;
        end else begin
            case (state)
                STATE_RECV: if (goodFrame) state <= STATE_HOLD;
                STATE_HOLD: if (RvviReady) state <= STATE_RECV;
                default:    state <= STATE_RECV;
            endcase
        end
    end

    // Saturating beat counter and sticky strobe error, both cleared at frame end
    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            wordCount <= '0;
            stickyErr <= 1'b0;
        end else if (beat) begin
            if (RvviAxiRlast) begin
                wordCount <= '0;
                stickyErr <= 1'b0;
            end else begin
                wordCount <= (wordCount != WCNT_MAX) ? wordCount + 10'd1 : wordCount;
                stickyErr <= stickyNext;
            end
        end
    end

    // Presented record only changes when a good frame is accepted
    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            rvvi <= '0;
        end else if (goodFrame) begin
            rvvi <= frameNext[PAYLOAD_OFF +: RVVI_W];
        end
    end

    // Drop pulse and wrapping good/drop counters
    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            FrameErr   <= 1'b0;
            FrameCount <= 32'd0;
            DropCount  <= 32'd0;
        end else begin
            FrameErr <= badFrame;
            if (goodFrame) FrameCount <= FrameCount + 32'd1;
            if (badFrame)  DropCount  <= DropCount + 32'd1;
        end
    end

endmodule
